gcd_ctrl: RTL and testbench

//  FSM controller for the subtractive GCD datapath (gcd_dp). Sequences operand load,

---
 rtl/gcd_ctrl_if.sv | 28 ++
 rtl/gcd_ctrl.sv | 155 +++++++++++++++
 tb/tb_gcd_ctrl.sv | 239 +++++++++++++++++++++++
 3 files changed

// File: rtl/gcd_ctrl_if.sv
// Host/datapath signal bundle for the subtractive GCD controller.
// The master side is the host plus datapath; the slave side is gcd_ctrl.
interface gcd_ctrl_if #(
  parameter int ITER_W = 8
);
  logic              start;
  logic [1:0]        compare_state;
  logic              ld_A;
  logic              ld_B;
  logic              MUXA;
  logic              MUXB;
  logic              res_en;
  logic              busy;
  logic              done;
  logic              error;
  logic [ITER_W-1:0] iter_count;
  logic [2:0]        dbg_state;

  modport master (
    output start, compare_state,
    input  ld_A, ld_B, MUXA, MUXB, res_en, busy, done, error, iter_count, dbg_state
  );

  modport slave (
    input  start, compare_state,
    output ld_A, ld_B, MUXA, MUXB, res_en, busy, done, error, iter_count, dbg_state
  );
endinterface

// File: rtl/gcd_ctrl.sv
// Controller for the subtractive GCD datapath: load, subtract until equal, capture,
// with a watchdog that aborts runs that would never terminate (zero operands).
module gcd_ctrl #(
  parameter int ITER_W   = 8,
  parameter int MAX_ITER = 200
) (
  input logic       clk,
  input logic       rst,
  gcd_ctrl_if.slave bus
);

  // Handshake: start is sampled only in IDLE or DONE; busy is high for LOAD and CALC;
  // exactly one of done/error pulses for one cycle to end each accepted run, and
  // iter_count then holds until the next LOAD.

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    LOAD = 3'd1,
    CALC = 3'd2,
    DONE = 3'd3,
    ERR  = 3'd4
  } state_t;

  localparam logic [1:0] CMP_GT  = 2'd0;
  localparam logic [1:0] CMP_LT  = 2'd1;
  localparam logic [1:0] CMP_EQ  = 2'd2;

  localparam logic [ITER_W-1:0] MAX_CNT = ITER_W'(MAX_ITER);

  state_t            state;
  state_t            state_next;
  logic [ITER_W-1:0] iter;
  logic              cnt_clr;
  logic              cnt_inc;
  logic              wd_hit;

  logic              ld_a;
  logic              ld_b;
  logic              mux_a;
  logic              mux_b;
  logic              res_en;
  logic              busy;
  logic              done;
  logic              error;

  assign wd_hit = (iter == MAX_CNT);

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      iter  <= '0;
    end else begin
      state <= state_next;
      if (cnt_clr) begin
        iter <= '0;
      end else if (cnt_inc) begin
        iter <= iter + 1'b1;
      end
    end
  end

  always_comb begin
    state_next = state;
    cnt_clr    = 1'b0;
    cnt_inc    = 1'b0;
    ld_a       = 1'b0;
    ld_b       = 1'b0;
    mux_a      = 1'b0;
    mux_b      = 1'b0;
    res_en     = 1'b0;
    busy       = 1'b0;
    done       = 1'b0;
    error      = 1'b0;

    unique case (state)
      IDLE: begin
        if (bus.start) begin
          state_next = LOAD;
          cnt_clr    = 1'b1;
        end
      end

      LOAD: begin
        ld_a       = 1'b1;
        ld_b       = 1'b1;
        mux_a      = 1'b1;
        mux_b      = 1'b1;
        busy       = 1'b1;
        state_next = CALC;
      end

      CALC: begin
        busy = 1'b1;
        // Equal wins over the watchdog so a run finishing on its last allowed
        // count still reports a result.
        unique case (bus.compare_state)
          CMP_EQ: begin
            res_en     = 1'b1;
            state_next = DONE;
          end
          CMP_GT: begin
            if (wd_hit) begin
              state_next = ERR;
            end else begin
              ld_a    = 1'b1;
              cnt_inc = 1'b1;
            end
          end
          CMP_LT: begin
            if (wd_hit) begin
              state_next = ERR;
            end else begin
              ld_b    = 1'b1;
              cnt_inc = 1'b1;
            end
          end
          default: begin
            state_next = ERR;
          end
        endcase
      end

      DONE: begin
        done = 1'b1;
        if (bus.start) begin
          state_next = LOAD;
          cnt_clr    = 1'b1;
        end else begin
          state_next = IDLE;
        end
      end

      ERR: begin
        error      = 1'b1;
        state_next = IDLE;
      end

      default: begin
        state_next = IDLE;
      end
    endcase
  end

  assign bus.ld_A       = ld_a;
  assign bus.ld_B       = ld_b;
  assign bus.MUXA       = mux_a;
  assign bus.MUXB       = mux_b;
  assign bus.res_en     = res_en;
  assign bus.busy       = busy;
  assign bus.done       = done;
  assign bus.error      = error;
  assign bus.iter_count = iter;
  assign bus.dbg_state  = state;

endmodule

// File: tb/tb_gcd_ctrl.sv
// Bench for gcd_ctrl: a behavioural gcd_dp closes the loop, table-driven runs plus
// hand sequences for back-to-back starts, illegal compare, and mid-run reset.
module tb_gcd_ctrl;

  localparam int ITER_W   = 8;
  localparam int MAX_ITER = 16;
  localparam int DW       = 16;
  localparam int SBW      = 1 + DW + ITER_W;

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_LOAD = 3'd1;
  localparam logic [2:0] S_CALC = 3'd2;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  gcd_ctrl_if #(.ITER_W(ITER_W)) bus ();

  gcd_ctrl #(.ITER_W(ITER_W), .MAX_ITER(MAX_ITER)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // ---------------- datapath model ----------------
  logic [DW-1:0] in_a    = '0;
  logic [DW-1:0] in_b    = '0;
  logic [DW-1:0] reg_a   = '0;
  logic [DW-1:0] reg_b   = '0;
  logic [DW-1:0] reg_res = '0;
  logic          force_illegal = 1'b0;

  always_ff @(posedge clk) begin
    if (bus.ld_A) reg_a <= bus.MUXA ? in_a : reg_a - reg_b;
    if (bus.ld_B) reg_b <= bus.MUXB ? in_b : reg_b - reg_a;
    if (bus.res_en) reg_res <= reg_a;
  end

  always_comb begin
    bus.compare_state = 2'd2;
    if (force_illegal)      bus.compare_state = 2'd3;
    else if (reg_a > reg_b) bus.compare_state = 2'd0;
    else if (reg_a < reg_b) bus.compare_state = 2'd1;
  end

  // ---------------- checking ----------------
  int checks = 0;
  int errors = 0;
  logic [SBW-1:0] exp_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [SBW-1:0] mk_exp(input bit err, input logic [DW-1:0] res,
                                            input int iter);
    return {err, res, ITER_W'(iter)};
  endfunction

  // Scoreboard: one entry per accepted run, popped at its done/error pulse.
  always @(negedge clk) begin
    logic [SBW-1:0] e;
    if (rst === 1'b0) begin
      if (bus.done || bus.error) begin
        if (exp_q.size() == 0) begin
          check("sb_unexpected_end", 1, 0);
        end else begin
          e = exp_q.pop_front();
          check("sb_error_flag", 32'(bus.error), 32'(e[SBW-1]));
          check("sb_iter_count", 32'(bus.iter_count), 32'(e[ITER_W-1:0]));
          if (!e[SBW-1]) check("sb_result", 32'(reg_res), 32'(e[SBW-2:ITER_W]));
        end
      end
      check("done_error_excl", 32'(bus.done && bus.error), 0);
      check("single_ld_calc", 32'(bus.ld_A && bus.ld_B && bus.dbg_state != S_LOAD), 0);
      check("mux_outside_load", 32'((bus.MUXA || bus.MUXB) && bus.dbg_state != S_LOAD), 0);
    end
  end

  // ---------------- driver tasks ----------------
  task automatic run_op(input string tag, input logic [DW-1:0] a, input logic [DW-1:0] b,
                        input logic [DW-1:0] exp_res, input int exp_iter, input bit exp_err);
    int lat, busy_n, ld_n, res_n;
    bit fin;
    @(negedge clk);
    in_a = a;
    in_b = b;
    bus.start = 1'b1;
    exp_q.push_back(mk_exp(exp_err, exp_res, exp_iter));
    @(posedge clk);
    #1 bus.start = 1'b0;
    lat = 0; busy_n = 0; ld_n = 0; res_n = 0; fin = 0;
    while (!fin && lat < 300) begin
      @(negedge clk);
      lat++;
      if (bus.busy) busy_n++;
      if (bus.ld_A) ld_n++;
      if (bus.ld_B) ld_n++;
      if (bus.res_en) res_n++;
      if (bus.done || bus.error) fin = 1;
    end
    check({tag, "_finished"}, 32'(fin), 1);
    check({tag, "_latency"}, 32'(lat), 32'(3 + exp_iter));
    check({tag, "_busy_cycles"}, 32'(busy_n), 32'(2 + exp_iter));
    check({tag, "_ld_pulses"}, 32'(ld_n), 32'(2 + exp_iter));
    check({tag, "_res_en"}, 32'(res_n), exp_err ? 0 : 1);
  endtask

  task automatic wait_done(input string tag);
    int n = 0;
    while (!bus.done && n < 300) begin
      @(negedge clk);
      n++;
    end
    check({tag, "_done_seen"}, 32'(bus.done), 1);
  endtask

  // ---------------- vectors ----------------
  typedef struct {
    logic [DW-1:0] a;
    logic [DW-1:0] b;
    logic [DW-1:0] res;
    int            iter;
    bit            err;
  } vec_t;

  vec_t vecs[10];

  initial begin
    logic [DW-1:0] res_before;
    bus.start = 1'b0;

    vecs[0] = '{a: 12, b: 8,  res: 4, iter: 2,  err: 0};
    vecs[1] = '{a: 7,  b: 7,  res: 7, iter: 0,  err: 0};
    vecs[2] = '{a: 48, b: 18, res: 6, iter: 4,  err: 0};
    vecs[3] = '{a: 21, b: 14, res: 7, iter: 2,  err: 0};
    vecs[4] = '{a: 1,  b: 1,  res: 1, iter: 0,  err: 0};
    vecs[5] = '{a: 0,  b: 0,  res: 0, iter: 0,  err: 0};
    vecs[6] = '{a: 17, b: 1,  res: 1, iter: 16, err: 0};   // equal on the last allowed count
    vecs[7] = '{a: 18, b: 1,  res: 0, iter: 16, err: 1};   // one subtraction too many
    vecs[8] = '{a: 0,  b: 5,  res: 0, iter: 16, err: 1};
    vecs[9] = '{a: 5,  b: 0,  res: 0, iter: 16, err: 1};

    // Reset state
    rst = 1'b1;
    bus.start = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_state", 32'(bus.dbg_state), 32'(S_IDLE));
    check("rst_busy", 32'(bus.busy), 0);
    check("rst_done", 32'(bus.done), 0);
    check("rst_error", 32'(bus.error), 0);
    check("rst_iter", 32'(bus.iter_count), 0);
    check("rst_loads", 32'({bus.ld_A, bus.ld_B, bus.MUXA, bus.MUXB, bus.res_en}), 0);
    bus.start = 1'b0;
    rst = 1'b0;
    @(negedge clk);

    for (int i = 0; i < 10; i++) begin
      run_op($sformatf("vec%0d", i), vecs[i].a, vecs[i].b, vecs[i].res, vecs[i].iter,
             vecs[i].err);
      @(negedge clk);
      check($sformatf("vec%0d_idle_after", i), 32'(bus.dbg_state), 32'(S_IDLE));
      check($sformatf("vec%0d_iter_hold", i), 32'(bus.iter_count), 32'(vecs[i].iter));
    end

    // Illegal compare_state in CALC: no loads, error next cycle, result untouched
    res_before = reg_res;
    force_illegal = 1'b1;
    run_op("illegal", 16'd20, 16'd6, 16'd0, 0, 1'b1);
    force_illegal = 1'b0;
    check("illegal_res_kept", 32'(reg_res), 32'(res_before));
    @(negedge clk);
    check("illegal_idle", 32'(bus.dbg_state), 32'(S_IDLE));

    // start held high: DONE goes straight to LOAD; a start pulse while busy is ignored
    @(negedge clk);
    in_a = 16'd12;
    in_b = 16'd8;
    bus.start = 1'b1;
    exp_q.push_back(mk_exp(1'b0, 16'd4, 2));
    wait_done("b2b_first");
    in_a = 16'd48;
    in_b = 16'd18;
    exp_q.push_back(mk_exp(1'b0, 16'd6, 4));
    @(negedge clk);
    check("b2b_load_state", 32'(bus.dbg_state), 32'(S_LOAD));
    check("b2b_load_busy", 32'(bus.busy), 1);
    check("b2b_iter_cleared", 32'(bus.iter_count), 0);
    bus.start = 1'b0;
    repeat (2) @(negedge clk);
    check("b2b_in_calc", 32'(bus.dbg_state), 32'(S_CALC));
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    wait_done("b2b_second");
    @(negedge clk);
    check("b2b_idle_after", 32'(bus.dbg_state), 32'(S_IDLE));
    check("b2b_not_busy", 32'(bus.busy), 0);
    repeat (4) @(negedge clk);
    check("b2b_no_extra_run", 32'(exp_q.size()), 0);

    // Reset during a long CALC aborts at once; the next run is unaffected
    @(negedge clk);
    in_a = 16'd1000;
    in_b = 16'd1;
    bus.start = 1'b1;
    @(posedge clk);
    #1 bus.start = 1'b0;
    repeat (5) @(negedge clk);
    check("abort_in_calc", 32'(bus.dbg_state), 32'(S_CALC));
    rst = 1'b1;
    @(negedge clk);
    check("abort_state", 32'(bus.dbg_state), 32'(S_IDLE));
    check("abort_outputs",
          32'({bus.ld_A, bus.ld_B, bus.MUXA, bus.MUXB, bus.res_en, bus.busy, bus.done,
               bus.error}), 0);
    check("abort_iter", 32'(bus.iter_count), 0);
    rst = 1'b0;
    run_op("after_abort", 16'd9, 16'd6, 16'd3, 2, 1'b0);

    repeat (3) @(negedge clk);
    check("sb_drained", 32'(exp_q.size()), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: got no finish expected finish");
    $fatal(1, "timeout");
  end

endmodule
